// File: rtl/rab_w_sender.sv
// rab_w_sender: gates buffered W beats on a per-burst forward/drop decision
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   ctrl_valid_i/ready_o        per-burst translation decision handshake
//   ctrl_drop_i, ctrl_id_i      1 = drop burst; AXI ID of the burst
//   s_w_*                       W beats from the RAB W buffer
//   m_w_*                       W beats towards the master side
//   err_b_id/resp/valid/ready   SLVERR response for dropped bursts
//   drop_cnt_o                  saturating count of dropped bursts
//
// Optional feature: define RAB_W_ERR_RESP_EN to emit one SLVERR B beat per
// dropped burst. Without it the error channel is tied off and DROP returns
// straight to IDLE.
module rab_w_sender #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int ID_WIDTH   = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    ctrl_valid_i,
    output logic                    ctrl_ready_o,
    input  logic                    ctrl_drop_i,
    input  logic [ID_WIDTH-1:0]     ctrl_id_i,
    input  logic [DATA_WIDTH-1:0]   s_w_data_i,
    input  logic [DATA_WIDTH/8-1:0] s_w_strb_i,
    input  logic                    s_w_last_i,
    input  logic [USER_WIDTH-1:0]   s_w_user_i,
    input  logic                    s_w_valid_i,
    output logic                    s_w_ready_o,
    output logic [DATA_WIDTH-1:0]   m_w_data_o,
    output logic [DATA_WIDTH/8-1:0] m_w_strb_o,
    output logic                    m_w_last_o,
    output logic [USER_WIDTH-1:0]   m_w_user_o,
    output logic                    m_w_valid_o,
    input  logic                    m_w_ready_i,
    output logic [ID_WIDTH-1:0]     err_b_id_o,
    output logic [1:0]              err_b_resp_o,
    output logic                    err_b_valid_o,
    input  logic                    err_b_ready_i,
    output logic [CNT_WIDTH-1:0]    drop_cnt_o
);
`ifdef RAB_W_ERR_RESP_EN
    typedef enum logic [1:0] {IDLE, FWD, DROP, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
`endif
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 last_hs;
    assign last_hs      = s_w_valid_i & s_w_ready_o & s_w_last_i;
    assign ctrl_ready_o = state == IDLE;
    assign s_w_ready_o  = (state == DROP) | ((state == FWD) & m_w_ready_i);
    assign m_w_valid_o  = (state == FWD) & s_w_valid_i;
    assign m_w_data_o   = s_w_data_i;
    assign m_w_strb_o   = s_w_strb_i;
    assign m_w_last_o   = s_w_last_i;
    assign m_w_user_o   = s_w_user_i;
    assign drop_cnt_o   = cnt_q;
`ifdef RAB_W_ERR_RESP_EN
    logic [ID_WIDTH-1:0] id_q;
    assign err_b_valid_o = state == RESP;
    assign err_b_id_o    = id_q;
    assign err_b_resp_o  = 2'b10;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            id_q <= '0;
        else if (ctrl_ready_o && ctrl_valid_i && ctrl_drop_i)
            id_q <= ctrl_id_i;
    end
`else
    logic unused_err;
    assign unused_err    = ^{ctrl_id_i, err_b_ready_i};
    assign err_b_valid_o = 1'b0;
    assign err_b_id_o    = '0;
    assign err_b_resp_o  = 2'b00;
`endif
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: if (ctrl_valid_i) state <= ctrl_drop_i ? DROP : FWD;
                FWD:  if (last_hs) state <= IDLE;
                DROP: if (last_hs) begin
`ifdef RAB_W_ERR_RESP_EN
                    state <= RESP;
`else
                    state <= IDLE;
`endif
                    cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
`ifdef RAB_W_ERR_RESP_EN
                RESP: if (err_b_ready_i) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rab_w_sender.sv
// tb_rab_w_sender: table-driven check of rab_w_sender with a 2-bit drop counter
module tb_rab_w_sender;
`ifdef RAB_W_ERR_RESP_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    typedef struct {
        logic        cv, cd;
        logic [9:0]  id;
        logic        sv, sl;
        logic [63:0] d;
        logic        mr, er;
        logic        cr, sr, mv, ev;
        logic [9:0]  eid;
        logic [1:0]  cnt;
    } row_t;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        ctrl_valid = 1'b0, ctrl_ready, ctrl_drop = 1'b0;
    logic [9:0]  ctrl_id = '0;
    logic [63:0] s_data = '0, m_data;
    logic [7:0]  s_strb = '0, m_strb;
    logic        s_last = 1'b0, s_valid = 1'b0, s_ready, m_last, m_valid, m_ready = 1'b0;
    logic [5:0]  s_user = '0, m_user;
    logic [9:0]  err_id;
    logic [1:0]  err_resp, cnt;
    logic        err_valid, err_ready = 1'b0;

    row_t q[$];
    logic [1:0] ecnt;
    logic [9:0] eid;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rab_w_sender #(.CNT_WIDTH(2)) dut (
        .clk(clk), .rstn(rstn),
        .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready),
        .ctrl_drop_i(ctrl_drop), .ctrl_id_i(ctrl_id),
        .s_w_data_i(s_data), .s_w_strb_i(s_strb), .s_w_last_i(s_last),
        .s_w_user_i(s_user), .s_w_valid_i(s_valid), .s_w_ready_o(s_ready),
        .m_w_data_o(m_data), .m_w_strb_o(m_strb), .m_w_last_o(m_last),
        .m_w_user_o(m_user), .m_w_valid_o(m_valid), .m_w_ready_i(m_ready),
        .err_b_id_o(err_id), .err_b_resp_o(err_resp), .err_b_valid_o(err_valid),
        .err_b_ready_i(err_ready), .drop_cnt_o(cnt)
    );

    task automatic add(input logic cv, cd, input logic [9:0] id, input logic sv, sl,
                       input logic mr, er, cr, sr, mv, ev);
        row_t r;
        r.cv = cv; r.cd = cd; r.id = id; r.sv = sv; r.sl = sl;
        r.d = {$urandom, $urandom}; r.mr = mr; r.er = er;
        r.cr = cr; r.sr = sr; r.mv = mv; r.ev = ev; r.eid = eid; r.cnt = ecnt;
        q.push_back(r);
    endtask

    task automatic fwd_burst(input int n, input int stall_at, input int stall_len, input logic hold);
        add(1, 0, 10'h3C5, 1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at)
                for (int k = 0; k < stall_len; k++) begin
                    add(hold, 0, '0, 1, i == n - 1, 0, 0, 0, 0, 1, 0);
                    q[$].d = q[$ - k].d;
                end
            add(hold, 0, '0, 1, i == n - 1, 1, 0, 0, 1, 1, 0);
            if (i == stall_at && stall_len > 0) q[$].d = q[$ - 1].d;
        end
    endtask

    task automatic drop_burst(input logic [9:0] id, input int n, input int resp_wait);
        add(1, 1, id, 1, 0, 0, 0, 1, 0, 0, 0);
        eid = ERR ? id : 10'h0;
        for (int i = 0; i < n; i++) add(0, 0, '0, 1, i == n - 1, 0, 0, 0, 1, 0, 0);
        ecnt = (&ecnt) ? ecnt : ecnt + 2'd1;
        if (ERR) begin
            for (int w = 0; w < resp_wait; w++) add(0, 0, '0, 0, 0, 1, 0, 0, 0, 0, 1);
            add(0, 0, '0, 0, 0, 1, 1, 0, 0, 0, 1);
        end
    endtask

    task automatic check(input string name, input logic [96:0] got, input logic [96:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [96:0] dut_out();
        return {ctrl_ready, s_ready, m_valid, m_last, m_data, m_strb, m_user,
                err_valid, err_id, err_resp, cnt};
    endfunction

    task automatic run_table(input string tag);
        foreach (q[i]) begin
            @(negedge clk);
            ctrl_valid = q[i].cv; ctrl_drop = q[i].cd; ctrl_id = q[i].id;
            s_valid = q[i].sv; s_last = q[i].sl; s_data = q[i].d;
            s_strb = q[i].d[7:0]; s_user = q[i].d[5:0];
            m_ready = q[i].mr; err_ready = q[i].er;
            #1;
            check($sformatf("%s_row%0d", tag, i), dut_out(),
                  {q[i].cr, q[i].sr, q[i].mv, q[i].sl, q[i].d, q[i].d[7:0], q[i].d[5:0],
                   q[i].ev, q[i].eid, ERR ? 2'b10 : 2'b00, q[i].cnt});
        end
        q.delete();
    endtask

    function automatic logic [96:0] reset_exp();
        return {1'b1, 1'b0, 1'b0, s_last, s_data, s_strb, s_user,
                1'b0, 10'h0, ERR ? 2'b10 : 2'b00, 2'd0};
    endfunction

    initial begin
        ecnt = 0;
        eid = 0;
        #1;
        check("reset_state", dut_out(), reset_exp());
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        fwd_burst(4, -1, 0, 0);
        fwd_burst(4, 2, 3, 1);
        drop_burst(10'h2A, 8, 1);
        drop_burst(10'h15, 1, 0);
        drop_burst(10'h3FF, 1, 0);
        drop_burst(10'h001, 2, 0);
        drop_burst(10'h100, 1, 0);
        fwd_burst(1, -1, 0, 0);
        run_table("main");
        fwd_burst(2, -1, 0, 0);
        q[2].sl = 1'b0;
        run_table("pre_rst");
        #2;
        rstn = 1'b0;
        #1;
        check("mid_burst_reset", dut_out(), reset_exp());
        @(negedge clk);
        check("reset_held", dut_out(), reset_exp());
        rstn = 1'b1;
        ecnt = 0;
        eid = 0;
        fwd_burst(4, -1, 0, 0);
        drop_burst(10'h07, 1, 0);
        run_table("post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
